// File: rtl/tx_dispatch_ctrl.sv
// rtl/tx_dispatch_ctrl.sv - pops FWFT FIFO words into a UART TX, one frame per busy pulse.
// Launch, wait for the TX busy rise (with timeout), then wait for the busy fall.
module tx_dispatch_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TX_ENABLE,
  input  logic                  FIFO_EMPTY,
  input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
  input  logic                  TX_BUSY,
  input  logic                  CLR_ERR,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_DATA_VALID,
  output logic                  FIFO_RD_INC,
  output logic [7:0]            DISPATCH_CNT,
  output logic                  TIMEOUT_ERR
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    WAIT_FALL = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(BUSY_TIMEOUT - 1);

  state_t     state;
  logic       busy_prev;
  logic [7:0] tmo_cnt;
  logic       busy_rise;
  logic       busy_fall;

  assign busy_rise = TX_BUSY & ~busy_prev;
  assign busy_fall = ~TX_BUSY & busy_prev;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      busy_prev     <= 1'b0;
      tmo_cnt       <= 8'd0;
      TX_P_DATA     <= '0;
      TX_DATA_VALID <= 1'b0;
      FIFO_RD_INC   <= 1'b0;
      DISPATCH_CNT  <= 8'd0;
      TIMEOUT_ERR   <= 1'b0;
    end else begin
      busy_prev     <= TX_BUSY;
      TX_DATA_VALID <= 1'b0;
      FIFO_RD_INC   <= 1'b0;
      // A timeout set below overrides this clear when both land in one cycle.
      if (CLR_ERR) begin
        TIMEOUT_ERR <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (TX_ENABLE && !FIFO_EMPTY && !TX_BUSY) begin
            TX_P_DATA     <= FIFO_RD_DATA;
            TX_DATA_VALID <= 1'b1;
            tmo_cnt       <= 8'd0;
            state         <= WAIT_RISE;
          end
        end
        WAIT_RISE: begin
          if (busy_rise) begin
            FIFO_RD_INC  <= 1'b1;
            DISPATCH_CNT <= DISPATCH_CNT + 8'd1;
            state        <= WAIT_FALL;
          end else if (tmo_cnt == TMO_LAST) begin
            // No pop: the head word stays in the FIFO and is relaunched.
            TIMEOUT_ERR <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        WAIT_FALL: begin
          if (busy_fall) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_dispatch_ctrl.sv
// tb/tb_tx_dispatch_ctrl.sv - self-checking bench for tx_dispatch_ctrl.
// A queue-based FIFO and a responsive TX busy emulator drive the DUT; expectations come from word lists and pop counts.
module tb_tx_dispatch_ctrl;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          TX_ENABLE = 1'b0;
  logic          FIFO_EMPTY = 1'b1;
  logic [DW-1:0] FIFO_RD_DATA = '0;
  logic          TX_BUSY = 1'b0;
  logic          CLR_ERR = 1'b0;
  logic [DW-1:0] TX_P_DATA;
  logic          TX_DATA_VALID;
  logic          FIFO_RD_INC;
  logic [7:0]    DISPATCH_CNT;
  logic          TIMEOUT_ERR;

  tx_dispatch_ctrl #(.DATA_WIDTH(DW), .BUSY_TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST), .TX_ENABLE(TX_ENABLE), .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_RD_DATA(FIFO_RD_DATA), .TX_BUSY(TX_BUSY), .CLR_ERR(CLR_ERR),
    .TX_P_DATA(TX_P_DATA), .TX_DATA_VALID(TX_DATA_VALID), .FIFO_RD_INC(FIFO_RD_INC),
    .DISPATCH_CNT(DISPATCH_CNT), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_pops = 0;

  logic [DW-1:0] fifoq[$];
  logic [DW-1:0] seen_q[$];
  int rd_total = 0, overlap = 0, rd_lat_bad = 0, min_gap_bad = 0;
  int last_rise_cyc = -100, last_valid_cyc = -100;
  bit busy_auto = 1'b0;
  int rise_left = 0, fall_left = 0;
  int rise_lo = 1, rise_hi = 8, hold_lo = 1, hold_hi = 6;

  always @(posedge CLK) cyc++;

  // Monitor, FIFO model and TX busy emulator, all acting on the falling edge.
  always @(negedge CLK) begin
    if (TX_DATA_VALID) begin
      seen_q.push_back(TX_P_DATA);
      if (cyc - last_valid_cyc < 4) min_gap_bad++;
      last_valid_cyc = cyc;
    end
    if (FIFO_RD_INC) begin
      rd_total++;
      if (TX_DATA_VALID) overlap++;
      if (busy_auto && cyc != last_rise_cyc + 1) rd_lat_bad++;
      if (fifoq.size() > 0) void'(fifoq.pop_front());
    end
    if (busy_auto) begin
      if (TX_DATA_VALID) begin
        rise_left = $urandom_range(rise_hi, rise_lo);
      end else if (rise_left > 0) begin
        rise_left--;
        if (rise_left == 0) begin
          TX_BUSY = 1'b1;
          last_rise_cyc = cyc;
          fall_left = $urandom_range(hold_hi, hold_lo);
        end
      end else if (fall_left > 0) begin
        fall_left--;
        if (fall_left == 0) TX_BUSY = 1'b0;
      end
    end
    FIFO_EMPTY = (fifoq.size() == 0);
    FIFO_RD_DATA = FIFO_EMPTY ? '0 : fifoq[0];
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (TX_DATA_VALID) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int quiet;
    quiet = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (fifoq.size() == 0 && !TX_BUSY && rise_left == 0 && fall_left == 0 && !TX_DATA_VALID) quiet++;
      else quiet = 0;
      if (quiet >= 3) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) step();
    checks++; if (TX_P_DATA !== 8'h00) begin errors++; $display("FAIL reset_tx_p_data: got %0h expected 0", TX_P_DATA); end
    checks++; if (TX_DATA_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", TX_DATA_VALID); end
    checks++; if (FIFO_RD_INC !== 1'b0) begin errors++; $display("FAIL reset_rd_inc: got %b expected 0", FIFO_RD_INC); end
    checks++; if (DISPATCH_CNT !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", DISPATCH_CNT); end
    checks++; if (TIMEOUT_ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", TIMEOUT_ERR); end
    RST = 1'b0;
    exp_pops = 0;
    step();
  endtask

  task automatic test_single_frame();
    bit ok;
    int base_rd, base_seen;
    base_rd = rd_total;
    base_seen = seen_q.size();
    rise_lo = 3; rise_hi = 3; hold_lo = 10; hold_hi = 10;
    busy_auto = 1'b1;
    TX_ENABLE = 1'b1;
    fifoq.push_back(8'hA5);
    wait_valid(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_valid_timeout: got no valid expected valid pulse"); end
    checks++; if (TX_P_DATA !== 8'hA5) begin errors++; $display("FAIL single_data: got %0h expected a5", TX_P_DATA); end
    wait_idle(100, ok);
    exp_pops += 1;
    checks++; if (!ok) begin errors++; $display("FAIL single_idle_timeout: got busy expected idle"); end
    checks++; if (seen_q.size() - base_seen != 1) begin errors++; $display("FAIL single_valid_count: got %0d expected 1", seen_q.size() - base_seen); end
    checks++; if (rd_total - base_rd != 1) begin errors++; $display("FAIL single_rd_count: got %0d expected 1", rd_total - base_rd); end
    checks++; if (DISPATCH_CNT !== 8'(exp_pops)) begin errors++; $display("FAIL single_cnt: got %0d expected %0d", DISPATCH_CNT, exp_pops % 256); end
    checks++; if (rd_lat_bad != 0) begin errors++; $display("FAIL single_rd_latency: got %0d late pops expected 0", rd_lat_bad); end
    checks++; if (TX_P_DATA !== 8'hA5) begin errors++; $display("FAIL single_data_hold: got %0h expected a5", TX_P_DATA); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int base_rd, base_seen, bad;
    logic [DW-1:0] exp_q[$];
    base_rd = rd_total;
    base_seen = seen_q.size();
    rise_lo = 1; rise_hi = 8; hold_lo = 1; hold_hi = 6;
    exp_q = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 6; i++) exp_q.push_back(8'($urandom));
    foreach (exp_q[i]) fifoq.push_back(exp_q[i]);
    wait_idle(400, ok);
    exp_pops += exp_q.size();
    checks++; if (!ok) begin errors++; $display("FAIL b2b_idle_timeout: got busy expected idle"); end
    checks++; if (seen_q.size() - base_seen != exp_q.size()) begin errors++; $display("FAIL b2b_valid_count: got %0d expected %0d", seen_q.size() - base_seen, exp_q.size()); end
    bad = 0;
    foreach (exp_q[i]) if (base_seen + i >= seen_q.size() || seen_q[base_seen + i] !== exp_q[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_order: got %0d wrong words expected 0", bad); end
    checks++; if (rd_total - base_rd != exp_q.size()) begin errors++; $display("FAIL b2b_rd_count: got %0d expected %0d", rd_total - base_rd, exp_q.size()); end
    checks++; if (DISPATCH_CNT !== 8'(exp_pops)) begin errors++; $display("FAIL b2b_cnt: got %0d expected %0d", DISPATCH_CNT, exp_pops % 256); end
    checks++; if (overlap != 0) begin errors++; $display("FAIL b2b_overlap: got %0d expected 0", overlap); end
    checks++; if (min_gap_bad != 0) begin errors++; $display("FAIL b2b_min_period: got %0d short frames expected 0", min_gap_bad); end
    checks++; if (rd_lat_bad != 0) begin errors++; $display("FAIL b2b_rd_latency: got %0d late pops expected 0", rd_lat_bad); end
  endtask

  task automatic test_timeout();
    bit ok;
    int n, base_rd;
    base_rd = rd_total;
    busy_auto = 1'b0;
    TX_BUSY = 1'b0;
    fifoq.push_back(8'h5A);
    wait_valid(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_valid_timeout: got no valid expected valid pulse"); end
    n = 0;
    while (!TIMEOUT_ERR && n < 40) begin
      step();
      n++;
    end
    checks++; if (n != 16) begin errors++; $display("FAIL tmo_latency: got %0d cycles expected 16", n); end
    checks++; if (rd_total != base_rd) begin errors++; $display("FAIL tmo_no_pop: got %0d pops expected 0", rd_total - base_rd); end
    CLR_ERR = 1'b1;
    step();
    CLR_ERR = 1'b0;
    checks++; if (TIMEOUT_ERR !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b expected 0", TIMEOUT_ERR); end
    checks++; if (TX_DATA_VALID !== 1'b1 || TX_P_DATA !== 8'h5A) begin errors++; $display("FAIL tmo_retry: got valid=%b data=%0h expected valid=1 data=5a", TX_DATA_VALID, TX_P_DATA); end
    repeat (15) step();
    CLR_ERR = 1'b1;
    step();
    CLR_ERR = 1'b0;
    checks++; if (TIMEOUT_ERR !== 1'b1) begin errors++; $display("FAIL tmo_set_wins: got %b expected 1", TIMEOUT_ERR); end
    rise_lo = 2; rise_hi = 4; hold_lo = 2; hold_hi = 4;
    busy_auto = 1'b1;
    wait_idle(100, ok);
    exp_pops += 1;
    checks++; if (rd_total - base_rd != 1) begin errors++; $display("FAIL tmo_final_pop: got %0d expected 1", rd_total - base_rd); end
    checks++; if (DISPATCH_CNT !== 8'(exp_pops)) begin errors++; $display("FAIL tmo_cnt: got %0d expected %0d", DISPATCH_CNT, exp_pops % 256); end
    checks++; if (TIMEOUT_ERR !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b expected 1", TIMEOUT_ERR); end
    CLR_ERR = 1'b1;
    step();
    CLR_ERR = 1'b0;
    checks++; if (TIMEOUT_ERR !== 1'b0) begin errors++; $display("FAIL tmo_clear2: got %b expected 0", TIMEOUT_ERR); end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int base_rd, base_seen;
    base_rd = rd_total;
    base_seen = seen_q.size();
    rise_lo = 4; rise_hi = 4; hold_lo = 3; hold_hi = 3;
    fifoq.push_back(8'h77);
    fifoq.push_back(8'h88);
    wait_valid(10, ok);
    TX_ENABLE = 1'b0;
    checks++; if (!ok || TX_P_DATA !== 8'h77) begin errors++; $display("FAIL en_first: got ok=%b data=%0h expected ok=1 data=77", ok, TX_P_DATA); end
    repeat (30) step();
    exp_pops += 1;
    checks++; if (rd_total - base_rd != 1) begin errors++; $display("FAIL en_inflight_pop: got %0d expected 1", rd_total - base_rd); end
    checks++; if (seen_q.size() - base_seen != 1) begin errors++; $display("FAIL en_blocked: got %0d launches expected 1", seen_q.size() - base_seen); end
    checks++; if (fifoq.size() != 1) begin errors++; $display("FAIL en_fifo_left: got %0d words expected 1", fifoq.size()); end
    TX_ENABLE = 1'b1;
    wait_valid(5, ok);
    checks++; if (!ok || TX_P_DATA !== 8'h88) begin errors++; $display("FAIL en_resume: got ok=%b data=%0h expected ok=1 data=88", ok, TX_P_DATA); end
    wait_idle(100, ok);
    exp_pops += 1;
    checks++; if (DISPATCH_CNT !== 8'(exp_pops)) begin errors++; $display("FAIL en_cnt: got %0d expected %0d", DISPATCH_CNT, exp_pops % 256); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int base_rd, base_seen;
    busy_auto = 1'b0;
    TX_BUSY = 1'b0;
    fifoq.push_back(8'h3C);
    fifoq.push_back(8'h4D);
    wait_valid(10, ok);
    TX_BUSY = 1'b1;
    step();
    checks++; if (FIFO_RD_INC !== 1'b1) begin errors++; $display("FAIL rmf_pop_on_rise: got %b expected 1", FIFO_RD_INC); end
    RST = 1'b1;
    step();
    exp_pops = 0;
    checks++; if ({TX_P_DATA, TX_DATA_VALID, FIFO_RD_INC, DISPATCH_CNT, TIMEOUT_ERR} !== '0) begin errors++;
      $display("FAIL rmf_outputs_zero: got data=%0h v=%b rd=%b cnt=%0d err=%b expected all 0", TX_P_DATA, TX_DATA_VALID, FIFO_RD_INC, DISPATCH_CNT, TIMEOUT_ERR); end
    step();
    RST = 1'b0;
    base_rd = rd_total;
    base_seen = seen_q.size();
    repeat (5) step();
    checks++; if (seen_q.size() != base_seen || rd_total != base_rd) begin errors++; $display("FAIL rmf_busy_blocks: got %0d launches %0d pops expected 0 0", seen_q.size() - base_seen, rd_total - base_rd); end
    TX_BUSY = 1'b0;
    step();
    checks++; if (TX_DATA_VALID !== 1'b1 || TX_P_DATA !== 8'h4D) begin errors++; $display("FAIL rmf_relaunch: got valid=%b data=%0h expected valid=1 data=4d", TX_DATA_VALID, TX_P_DATA); end
    TX_BUSY = 1'b1;
    repeat (3) step();
    TX_BUSY = 1'b0;
    wait_idle(50, ok);
    exp_pops += 1;
    checks++; if (DISPATCH_CNT !== 8'(exp_pops)) begin errors++; $display("FAIL rmf_cnt: got %0d expected %0d", DISPATCH_CNT, exp_pops % 256); end
  endtask

  task automatic test_wrap();
    bit ok;
    int base_rd, base_seen, bad;
    logic [DW-1:0] exp_q[$];
    RST = 1'b1;
    step();
    RST = 1'b0;
    exp_pops = 0;
    base_rd = rd_total;
    base_seen = seen_q.size();
    rise_lo = 1; rise_hi = 2; hold_lo = 1; hold_hi = 2;
    busy_auto = 1'b1;
    for (int i = 0; i < 256; i++) exp_q.push_back(8'($urandom));
    foreach (exp_q[i]) fifoq.push_back(exp_q[i]);
    wait_idle(6000, ok);
    exp_pops += 256;
    checks++; if (!ok) begin errors++; $display("FAIL wrap_idle_timeout: got busy expected idle"); end
    checks++; if (rd_total - base_rd != 256) begin errors++; $display("FAIL wrap_rd_count: got %0d expected 256", rd_total - base_rd); end
    checks++; if (DISPATCH_CNT !== 8'(exp_pops)) begin errors++; $display("FAIL wrap_cnt: got %0d expected %0d", DISPATCH_CNT, exp_pops % 256); end
    bad = 0;
    foreach (exp_q[i]) if (base_seen + i >= seen_q.size() || seen_q[base_seen + i] !== exp_q[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL wrap_order: got %0d wrong words expected 0", bad); end
    checks++; if (overlap != 0 || min_gap_bad != 0) begin errors++; $display("FAIL wrap_pulses: got overlap=%0d short=%0d expected 0 0", overlap, min_gap_bad); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_timeout();
    test_enable_drop();
    test_reset_mid_frame();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
